// File: rtl/beam_power_scan.sv
// beam_power_scan
//   Per-beam power accumulator and strongest-beam finder. Takes the combined
//   per-beam I/Q sums from the 16-beam MAC combiner, scales and saturates them,
//   squares, and accumulates energy over each sop..eop window. The window result
//   is published on o_pwr, then a sequential argmax scan reports the strongest beam.
//
// Ports
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_data_i / i_data_q   per-beam signed I/Q sums [BEAM][OW]
//   i_tvalid              sample valid
//   i_sop / i_eop         window start / end (qualified by i_tvalid)
//   i_symb_clr            abort/clear (unqualified)
//   i_symb_1st            first-symbol flag, captured at valid sop
//   o_pwr                 per-beam window energy [BEAM][PW], held until next window
//   o_pwr_valid           one-cycle pulse when o_pwr updates
//   o_symb_1st            i_symb_1st of the published window
//   o_max_idx / o_max_pwr strongest beam and its energy
//   o_max_valid           one-cycle pulse when o_max_* update
//   o_overrun             one-cycle pulse, a new window finished during a scan
//
// Pipeline: S0 input regs -> S1 shift/saturate -> S2 I^2+Q^2 -> S3 accumulate.
//
// Scan FSM states
//   state   | meaning
//   IDLE    | waiting for o_pwr_valid
//   SCAN    | comparing beam idx against the running best, one beam per cycle

module beam_power_scan #(
    parameter int BEAM  = 16,
    parameter int OW    = 48,
    parameter int SHIFT = 20,
    parameter int SW    = 16,
    parameter int PW    = 40
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [BEAM-1:0][OW-1:0]      i_data_i,
    input  logic [BEAM-1:0][OW-1:0]      i_data_q,
    input  logic                         i_tvalid,
    input  logic                         i_sop,
    input  logic                         i_eop,
    input  logic                         i_symb_clr,
    input  logic                         i_symb_1st,
    output logic [BEAM-1:0][PW-1:0]      o_pwr,
    output logic                         o_pwr_valid,
    output logic                         o_symb_1st,
    output logic [$clog2(BEAM)-1:0]      o_max_idx,
    output logic [PW-1:0]                o_max_pwr,
    output logic                         o_max_valid,
    output logic                         o_overrun
);

    localparam int IW = $clog2(BEAM);
    localparam int P2 = 2 * SW;

    localparam logic signed [OW-1:0] SAT_HI = {{(OW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [OW-1:0] SAT_LO = {{(OW-SW+1){1'b1}}, {(SW-1){1'b0}}};

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    // ------------------------------------------------------------------
    // S0: input registers
    // ------------------------------------------------------------------
    logic [BEAM-1:0][OW-1:0] s0_i, s0_q;
    logic                    s0_vld, s0_sop, s0_eop, s0_symb, s0_clr;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s0_i    <= '0;
            s0_q    <= '0;
            s0_vld  <= 1'b0;
            s0_sop  <= 1'b0;
            s0_eop  <= 1'b0;
            s0_symb <= 1'b0;
            s0_clr  <= 1'b0;
        end else begin
            s0_i    <= i_data_i;
            s0_q    <= i_data_q;
            s0_vld  <= i_tvalid;
            s0_sop  <= i_sop;
            s0_eop  <= i_eop;
            s0_symb <= i_symb_1st;
            s0_clr  <= i_symb_clr;
        end
    end

    // ------------------------------------------------------------------
    // S1: arithmetic shift and saturate to SW bits
    // ------------------------------------------------------------------
    function automatic logic [SW-1:0] shift_sat(input logic [OW-1:0] v);
        logic signed [OW-1:0] sh;
        sh = $signed(v) >>> SHIFT;
        if (sh > SAT_HI)
            return SAT_HI[SW-1:0];
        else if (sh < SAT_LO)
            return SAT_LO[SW-1:0];
        else
            return sh[SW-1:0];
    endfunction

    logic [BEAM-1:0][SW-1:0] s1_i, s1_q;
    logic                    s1_vld, s1_sop, s1_eop, s1_symb;

    // s0_clr drops the sample sitting in S0 as well as everything behind it,
    // so a clear raised together with a valid sop discards that sop.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_i    <= '0;
            s1_q    <= '0;
            s1_vld  <= 1'b0;
            s1_sop  <= 1'b0;
            s1_eop  <= 1'b0;
            s1_symb <= 1'b0;
        end else begin
            s1_vld  <= s0_vld & ~s0_clr;
            s1_sop  <= s0_sop;
            s1_eop  <= s0_eop;
            s1_symb <= s0_symb;
            for (int k = 0; k < BEAM; k++) begin
                s1_i[k] <= shift_sat(s0_i[k]);
                s1_q[k] <= shift_sat(s0_q[k]);
            end
        end
    end

    // ------------------------------------------------------------------
    // S2: p = I^2 + Q^2 (unsigned, fits 2*SW bits since |x| <= 2^(SW-1))
    // ------------------------------------------------------------------
    function automatic logic [P2-1:0] mag2(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic signed [P2-1:0] ea, eb, aa, bb;
        ea = {{SW{a[SW-1]}}, a};
        eb = {{SW{b[SW-1]}}, b};
        aa = ea * ea;
        bb = eb * eb;
        return $unsigned(aa) + $unsigned(bb);
    endfunction

    logic [BEAM-1:0][P2-1:0] s2_p;
    logic                    s2_vld, s2_sop, s2_eop, s2_symb;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s2_p    <= '0;
            s2_vld  <= 1'b0;
            s2_sop  <= 1'b0;
            s2_eop  <= 1'b0;
            s2_symb <= 1'b0;
        end else begin
            s2_vld  <= s1_vld & ~s0_clr;
            s2_sop  <= s1_sop;
            s2_eop  <= s1_eop;
            s2_symb <= s1_symb;
            for (int k = 0; k < BEAM; k++)
                s2_p[k] <= mag2(s1_i[k], s1_q[k]);
        end
    end

    // ------------------------------------------------------------------
    // S3: window accumulation
    // ------------------------------------------------------------------
    logic [BEAM-1:0][PW-1:0] acc;
    logic [BEAM-1:0][PW-1:0] p_ext;
    logic [BEAM-1:0][PW-1:0] acc_sum;
    logic                    in_win;
    logic                    symb_cap;

    always_comb begin
        logic [PW:0] wide;
        p_ext   = '0;
        acc_sum = '0;
        wide    = '0;
        for (int k = 0; k < BEAM; k++) begin
            p_ext[k]   = {{(PW-P2){1'b0}}, s2_p[k]};
            wide       = {1'b0, acc[k]} + {1'b0, p_ext[k]};
            acc_sum[k] = wide[PW] ? {PW{1'b1}} : wide[PW-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc         <= '0;
            in_win      <= 1'b0;
            symb_cap    <= 1'b0;
            o_pwr       <= '0;
            o_pwr_valid <= 1'b0;
            o_symb_1st  <= 1'b0;
        end else begin
            o_pwr_valid <= 1'b0;
            if (s0_clr) begin
                acc    <= '0;
                in_win <= 1'b0;
            end else if (s2_vld) begin
                if (s2_sop) begin
                    acc      <= p_ext;
                    symb_cap <= s2_symb;
                    if (s2_eop) begin
                        o_pwr       <= p_ext;
                        o_pwr_valid <= 1'b1;
                        o_symb_1st  <= s2_symb;
                        in_win      <= 1'b0;
                    end else begin
                        in_win <= 1'b1;
                    end
                end else if (in_win) begin
                    acc <= acc_sum;
                    if (s2_eop) begin
                        o_pwr       <= acc_sum;
                        o_pwr_valid <= 1'b1;
                        o_symb_1st  <= symb_cap;
                        in_win      <= 1'b0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Argmax scan.
    // o_pwr only changes together with o_pwr_valid, and every o_pwr_valid
    // (re)starts the scan, so o_pwr itself is stable for the whole scan and
    // serves as the snapshot; no separate copy is kept.
    // ------------------------------------------------------------------
    state_t          state, state_nx;
    logic [IW-1:0]   idx, idx_nx;
    logic [IW-1:0]   best_idx, best_idx_nx;
    logic [PW-1:0]   best_pwr, best_pwr_nx;
    logic [IW-1:0]   max_idx_nx;
    logic [PW-1:0]   max_pwr_nx;
    logic            max_valid_nx;
    logic            overrun_nx;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            idx         <= '0;
            best_idx    <= '0;
            best_pwr    <= '0;
            o_max_idx   <= '0;
            o_max_pwr   <= '0;
            o_max_valid <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            best_idx    <= best_idx_nx;
            best_pwr    <= best_pwr_nx;
            o_max_idx   <= max_idx_nx;
            o_max_pwr   <= max_pwr_nx;
            o_max_valid <= max_valid_nx;
            o_overrun   <= overrun_nx;
        end
    end

    always_comb begin
        logic [IW-1:0] cand_idx;
        logic [PW-1:0] cand_pwr;
        state_nx     = state;
        idx_nx       = idx;
        best_idx_nx  = best_idx;
        best_pwr_nx  = best_pwr;
        max_idx_nx   = o_max_idx;
        max_pwr_nx   = o_max_pwr;
        max_valid_nx = 1'b0;
        overrun_nx   = 1'b0;
        cand_idx     = best_idx;
        cand_pwr     = best_pwr;

        if (s0_clr) begin
            state_nx = ST_IDLE;
            idx_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (o_pwr_valid) begin
                        best_idx_nx = '0;
                        best_pwr_nx = o_pwr[0];
                        idx_nx      = IW'(1);
                        state_nx    = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (o_pwr_valid) begin
                        overrun_nx  = 1'b1;
                        best_idx_nx = '0;
                        best_pwr_nx = o_pwr[0];
                        idx_nx      = IW'(1);
                    end else begin
                        // strict compare: on ties the lower index wins
                        if (o_pwr[idx] > best_pwr) begin
                            cand_idx = idx;
                            cand_pwr = o_pwr[idx];
                        end
                        best_idx_nx = cand_idx;
                        best_pwr_nx = cand_pwr;
                        if (idx == IW'(BEAM-1)) begin
                            max_idx_nx   = cand_idx;
                            max_pwr_nx   = cand_pwr;
                            max_valid_nx = 1'b1;
                            idx_nx       = '0;
                            state_nx     = ST_IDLE;
                        end else begin
                            idx_nx = idx + IW'(1);
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_beam_power_scan.sv
// Testbench for beam_power_scan. A bench-side model of the window logic pushes
// expected window energies, argmax results and overrun pulses (with the cycle
// they are due) into queues as stimulus is driven; a negedge monitor pops and
// compares them as the DUT produces them.

module tb_beam_power_scan;

    localparam int BEAM  = 16;
    localparam int OW    = 48;
    localparam int SHIFT = 0;
    localparam int SW    = 16;
    localparam int PW    = 40;
    localparam longint unsigned PMAX = (64'd1 << PW) - 64'd1;

    logic                     i_clk = 1'b0;
    logic                     i_reset = 1'b1;
    logic [BEAM-1:0][OW-1:0]  i_data_i = '0;
    logic [BEAM-1:0][OW-1:0]  i_data_q = '0;
    logic                     i_tvalid = 1'b0;
    logic                     i_sop = 1'b0;
    logic                     i_eop = 1'b0;
    logic                     i_symb_clr = 1'b0;
    logic                     i_symb_1st = 1'b0;
    logic [BEAM-1:0][PW-1:0]  o_pwr;
    logic                     o_pwr_valid;
    logic                     o_symb_1st;
    logic [$clog2(BEAM)-1:0]  o_max_idx;
    logic [PW-1:0]            o_max_pwr;
    logic                     o_max_valid;
    logic                     o_overrun;

    beam_power_scan #(
        .BEAM(BEAM), .OW(OW), .SHIFT(SHIFT), .SW(SW), .PW(PW)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_data_i    (i_data_i),
        .i_data_q    (i_data_q),
        .i_tvalid    (i_tvalid),
        .i_sop       (i_sop),
        .i_eop       (i_eop),
        .i_symb_clr  (i_symb_clr),
        .i_symb_1st  (i_symb_1st),
        .o_pwr       (o_pwr),
        .o_pwr_valid (o_pwr_valid),
        .o_symb_1st  (o_symb_1st),
        .o_max_idx   (o_max_idx),
        .o_max_pwr   (o_max_pwr),
        .o_max_valid (o_max_valid),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int               due;
        bit               symb;
        longint unsigned  p [BEAM];
    } pwr_rec_t;

    typedef struct {
        int               due;
        int               idx;
        longint unsigned  pwr;
    } max_rec_t;

    pwr_rec_t pwr_q [$];
    max_rec_t max_q [$];
    int       ovr_q [$];

    // model state
    bit                   m_in_win = 0;
    bit                   m_symb = 0;
    longint unsigned      m_acc [BEAM];
    logic signed [OW-1:0] s_i [BEAM];
    logic signed [OW-1:0] s_q [BEAM];

    function automatic longint lane(input logic signed [OW-1:0] v);
        longint s;
        s = v;
        s = s >>> SHIFT;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    function automatic longint unsigned pwr_of(input logic signed [OW-1:0] vi,
                                               input logic signed [OW-1:0] vq);
        longint a, b;
        a = lane(vi);
        b = lane(vq);
        return longint'(a * a + b * b);
    endfunction

    task automatic push_result(input int t);
        pwr_rec_t r;
        max_rec_t m;
        r.due  = t + 4;
        r.symb = m_symb;
        for (int k = 0; k < BEAM; k++) r.p[k] = m_acc[k];
        pwr_q.push_back(r);
        if (max_q.size() > 0 && max_q[max_q.size()-1].due > t + 4) begin
            max_q.delete(max_q.size() - 1);
            ovr_q.push_back(t + 5);
        end
        m.idx = 0;
        m.pwr = m_acc[0];
        for (int k = 1; k < BEAM; k++)
            if (m_acc[k] > m.pwr) begin
                m.idx = k;
                m.pwr = m_acc[k];
            end
        m.due = t + 20;
        max_q.push_back(m);
    endtask

    task automatic drive_sample(input bit v, input bit sop, input bit eop,
                                input bit clr, input bit symb);
        longint unsigned p, s;
        @(posedge i_clk);
        #1;
        for (int k = 0; k < BEAM; k++) begin
            i_data_i[k] = s_i[k];
            i_data_q[k] = s_q[k];
        end
        i_tvalid   = v;
        i_sop      = sop;
        i_eop      = eop;
        i_symb_clr = clr;
        i_symb_1st = symb;
        if (clr) begin
            m_in_win = 0;
            for (int k = 0; k < BEAM; k++) m_acc[k] = 0;
        end else if (v) begin
            if (sop) begin
                for (int k = 0; k < BEAM; k++) m_acc[k] = pwr_of(s_i[k], s_q[k]);
                m_in_win = 1;
                m_symb   = symb;
            end else if (m_in_win) begin
                for (int k = 0; k < BEAM; k++) begin
                    p = pwr_of(s_i[k], s_q[k]);
                    s = m_acc[k] + p;
                    m_acc[k] = (s > PMAX) ? PMAX : s;
                end
            end
            if (eop && m_in_win) begin
                push_result(cyc);
                m_in_win = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_sample(0, 0, 0, 0, 0);
    endtask

    task automatic set_all(input longint iv, input longint qv);
        for (int k = 0; k < BEAM; k++) begin
            s_i[k] = iv[OW-1:0];
            s_q[k] = qv[OW-1:0];
        end
    endtask

    task automatic set_rand(input int rng);
        longint r;
        for (int k = 0; k < BEAM; k++) begin
            r = longint'($urandom_range(0, 2 * rng)) - rng;
            s_i[k] = r[OW-1:0];
            r = longint'($urandom_range(0, 2 * rng)) - rng;
            s_q[k] = r[OW-1:0];
        end
    endtask

    // n-sample window; rng > 0 draws fresh random data for every sample
    task automatic window(input int n, input bit symb, input int rng);
        for (int j = 0; j < n; j++) begin
            if (rng > 0) set_rand(rng);
            drive_sample(1, j == 0, j == n - 1, 0, symb);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pwr"},       {63'd0, |o_pwr},       64'd0);
        chk({tag, "_pwr_valid"}, {63'd0, o_pwr_valid},  64'd0);
        chk({tag, "_symb"},      {63'd0, o_symb_1st},   64'd0);
        chk({tag, "_max_idx"},   64'(o_max_idx),        64'd0);
        chk({tag, "_max_pwr"},   64'(o_max_pwr),        64'd0);
        chk({tag, "_max_valid"}, {63'd0, o_max_valid},  64'd0);
        chk({tag, "_overrun"},   {63'd0, o_overrun},    64'd0);
    endtask

    // ------------------------------------------------------------------
    // monitor
    // ------------------------------------------------------------------
    pwr_rec_t mon_r;
    max_rec_t mon_m;
    int       mon_o;

    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (pwr_q.size() > 0 && cyc > pwr_q[0].due) begin
                chk("pwr_missing", 64'(cyc), 64'(pwr_q[0].due));
                void'(pwr_q.pop_front());
            end
            if (max_q.size() > 0 && cyc > max_q[0].due) begin
                chk("max_missing", 64'(cyc), 64'(max_q[0].due));
                void'(max_q.pop_front());
            end
            if (ovr_q.size() > 0 && cyc > ovr_q[0]) begin
                chk("overrun_missing", 64'(cyc), 64'(ovr_q[0]));
                void'(ovr_q.pop_front());
            end
            if (o_pwr_valid) begin
                if (pwr_q.size() == 0) begin
                    chk("pwr_unexpected", {63'd0, o_pwr_valid}, 64'd0);
                end else begin
                    mon_r = pwr_q.pop_front();
                    chk("pwr_cycle", 64'(cyc), 64'(mon_r.due));
                    for (int k = 0; k < BEAM; k++)
                        chk($sformatf("pwr[%0d]", k), 64'(o_pwr[k]), mon_r.p[k]);
                    chk("symb_1st", {63'd0, o_symb_1st}, {63'd0, mon_r.symb});
                end
            end
            if (o_max_valid) begin
                if (max_q.size() == 0) begin
                    chk("max_unexpected", {63'd0, o_max_valid}, 64'd0);
                end else begin
                    mon_m = max_q.pop_front();
                    chk("max_cycle", 64'(cyc), 64'(mon_m.due));
                    chk("max_idx", 64'(o_max_idx), 64'(mon_m.idx));
                    chk("max_pwr", 64'(o_max_pwr), mon_m.pwr);
                end
            end
            if (o_overrun) begin
                if (ovr_q.size() == 0) begin
                    chk("overrun_unexpected", {63'd0, o_overrun}, 64'd0);
                end else begin
                    mon_o = ovr_q.pop_front();
                    chk("overrun_cycle", 64'(cyc), 64'(mon_o));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // stimulus
    // ------------------------------------------------------------------
    initial begin
        for (int k = 0; k < BEAM; k++) m_acc[k] = 0;
        set_all(0, 0);

        repeat (3) @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        idle(2);

        // stray samples outside a window: no output expected
        set_rand(1000);
        drive_sample(1, 0, 0, 0, 1);
        drive_sample(1, 0, 1, 0, 1);
        idle(5);

        // beam k: I=k, Q=0, four samples -> 4k^2, argmax 15 / 900
        for (int k = 0; k < BEAM; k++) begin
            s_i[k] = k;
            s_q[k] = 0;
        end
        window(4, 1, 0);
        idle(25);

        // saturation of the shifted lane; beam 5 negative full scale
        set_all(0, 0);
        s_i[3] = 48'sd1048576;
        s_q[3] = 48'sd1048576;
        s_i[5] = -48'sd1048576;
        window(2, 0, 0);
        idle(25);

        // tie between beams 2 and 9 -> lowest index
        set_all(0, 0);
        s_i[2] = 7;
        s_q[9] = -7;
        window(3, 1, 0);
        idle(25);

        // random windows, single-sample window, restart on sop inside a window
        window(5, 0, 30000);
        idle(20);
        set_rand(20000);
        drive_sample(1, 1, 1, 0, 1);
        idle(20);
        set_rand(5000); drive_sample(1, 1, 0, 0, 1);
        set_rand(5000); drive_sample(1, 0, 0, 0, 1);
        set_rand(5000); drive_sample(1, 1, 0, 0, 0);
        set_rand(5000); drive_sample(1, 0, 1, 0, 0);
        idle(25);

        // clear on sample 4 of an 8-sample window, then a window of ones
        for (int j = 0; j < 8; j++) begin
            set_rand(3000);
            drive_sample(1, j == 0, j == 7, j == 3, 1);
        end
        idle(5);
        set_all(1, 0);
        window(2, 0, 0);
        idle(25);

        // back-to-back windows: eops 3 cycles apart -> one overrun
        window(2, 0, 3000);
        idle(1);
        window(2, 1, 3000);
        idle(30);

        // accumulator saturation at 2^PW-1
        set_all(48'sd1048576, 48'sd1048576);
        window(520, 1, 0);
        idle(25);

        // reset in the middle of a scan
        window(4, 0, 2000);
        idle(9);
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        pwr_q.delete();
        max_q.delete();
        ovr_q.delete();
        m_in_win = 0;
        i_tvalid = 1'b0;
        repeat (2) @(negedge i_clk);
        check_all_zero("midscan_reset");
        @(posedge i_clk);
        #1 i_reset = 1'b0;
        set_rand(1000);
        drive_sample(1, 0, 1, 0, 1);
        idle(30);
        chk("post_reset_max_idx", 64'(o_max_idx), 64'd0);
        chk("post_reset_max_valid", {63'd0, o_max_valid}, 64'd0);
        window(4, 1, 4000);
        idle(30);

        chk("pwr_queue_left", 64'(pwr_q.size()), 64'd0);
        chk("max_queue_left", 64'(max_q.size()), 64'd0);
        chk("ovr_queue_left", 64'(ovr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
